lfsr_seq_ctrl: RTL
==================

LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 4, giving the width of the controlled LFSR.
REQ-002 The block SHALL have parameter CNT_BITS, default 16, giving the width of the step and period counters.
REQ-003 Port i_Clk, input, 1: the single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 Port i_Rst_L, input, 1: reset, synchronous and active-low.
REQ-005 Port i_Start, input, 1: one-cycle run request; honoured only in IDLE.
REQ-006 Port i_Abort, input, 1: terminates any run in progress.
REQ-007 Port i_Seed, input, NUM_BITS: seed, captured with i_Start.
REQ-008 Port i_Steps, input, CNT_BITS: number of LFSR steps to run, captured with i_Start.
REQ-009 Port o_LFSR_Enable, output, 1: drives the LFSR enable.
REQ-010 Port o_LFSR_Seed_DV, output, 1: drives the LFSR seed strobe.
REQ-011 Port o_LFSR_Seed_Data, output, NUM_BITS: drives the LFSR seed value.
REQ-012 Port i_LFSR_Data, input, NUM_BITS: LFSR current state.
REQ-013 Port i_LFSR_Done, input, 1: LFSR sequence-complete flag.
REQ-014 Port o_Data, output, NUM_BITS: sampled LFSR state.
REQ-015 Port o_Data_DV, output, 1: o_Data valid strobe.
REQ-016 Port o_Busy, output, 1: high in every state except IDLE.
REQ-017 Port o_Done, output, 1: one-cycle run-complete pulse.
REQ-018 Port o_Error, output, 1: one-cycle pulse, coincident with o_Done, on a rejected or aborted run.
REQ-019 Port o_Wrapped, output, 1: i_LFSR_Done was observed during the last run.
REQ-020 Port o_Period, output, CNT_BITS: 1-based step index of the first i_LFSR_Done in the last run; 0 if none.

Function
REQ-021 The FSM SHALL have states IDLE, SEED, RUN and FINISH, encoded as registers.
REQ-022 IDLE, on i_Start=1: latch i_Seed and i_Steps; clear o_Wrapped and o_Period; go to SEED.
REQ-023 IDLE, i_Start with i_Seed=0: go to FINISH with the error flag set; no seed strobe is issued.
REQ-024 SEED (exactly 1 cycle): o_LFSR_Seed_DV=1, o_LFSR_Seed_Data=latched seed, o_LFSR_Enable=0; then go to RUN, or to FINISH if latched steps=0.
REQ-025 RUN: o_LFSR_Enable=1 every cycle; step counter increments from 0.
REQ-026 RUN: each cycle register o_Data<=i_LFSR_Data and o_Data_DV<=1, so the first sample equals the seed and exactly Steps samples are produced.
REQ-027 RUN: on the first cycle with i_LFSR_Done=1 at step index k≥1, set o_Wrapped=1 and o_Period=k; later Done assertions SHALL NOT change o_Period.
REQ-028 RUN SHALL exit to FINISH after the cycle in which step counter = Steps-1; o_LFSR_Enable SHALL be 0 from the next cycle.
REQ-029 FINISH (1 cycle): o_Done=1, o_Error per the error flag; then go to IDLE.
REQ-030 i_Abort in SEED or RUN: go to FINISH next cycle with the error flag set; o_LFSR_Enable and o_LFSR_Seed_DV SHALL be 0 from that cycle; o_Wrapped and o_Period hold their current values.
REQ-031 Simultaneous i_Abort and the last RUN step: i_Abort wins and o_Error=1.
REQ-032 i_Start outside IDLE SHALL be ignored.
REQ-033 i_Abort in IDLE or FINISH SHALL be ignored.
REQ-034 i_Start=1 during the FINISH cycle SHALL be ignored; a new run needs i_Start in IDLE.
REQ-035 Steps=2^CNT_BITS-1 SHALL run to completion without counter overflow.
REQ-036 o_Data_DV SHALL be 0 outside the cycle following each RUN sample.

Reset
REQ-037 With i_Rst_L=0 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL go to 0, including o_Data, o_Period and o_Wrapped.
REQ-038 Reset mid-run SHALL take effect on the next edge, with no o_Done pulse.
REQ-039 The controlled LFSR SHALL see o_LFSR_Enable=0 and o_LFSR_Seed_DV=0 throughout reset.

Verification
REQ-040 Bench: NUM_BITS=4, driving the team LFSR, which asserts Done every 15 steps. Seed=4'h1, Steps=20 -> one Seed_DV pulse; 20 o_Data_DV strobes, the first with o_Data=4'h1; o_Wrapped=1; o_Period=15; one o_Done; o_Error=0.
REQ-041 Seed=4'h1, Steps=10 -> 10 strobes; o_Wrapped=0; o_Period=0; o_Done=1.
REQ-042 Seed=4'h0 -> no Seed_DV and no strobes; o_Done and o_Error high together 1 cycle after start.
REQ-043 Steps=0, Seed=4'h3 -> one Seed_DV, zero strobes, o_Done with o_Error=0.
REQ-044 Abort at RUN step 5 of 20 -> exactly 5 strobes; o_Done=o_Error=1; o_LFSR_Enable=0 next cycle; a repeat i_Start while busy is ignored.
REQ-045 i_Rst_L=0 at step 7 -> all outputs 0 next cycle; no o_Done; a fresh run then behaves as in REQ-040.

Source files
------------

// File: rtl/lfsr_seq_ctrl_if.sv
// Bundle between lfsr_seq_ctrl and its host plus the LFSR it drives.
// slave: controller side; master: host/LFSR side.
interface lfsr_seq_ctrl_if #(
   parameter int NUM_BITS = 4,
   parameter int CNT_BITS = 16
);
   logic                i_Start;
   logic                i_Abort;
   logic [NUM_BITS-1:0] i_Seed;
   logic [CNT_BITS-1:0] i_Steps;
   logic                o_LFSR_Enable;
   logic                o_LFSR_Seed_DV;
   logic [NUM_BITS-1:0] o_LFSR_Seed_Data;
   logic [NUM_BITS-1:0] i_LFSR_Data;
   logic                i_LFSR_Done;
   logic [NUM_BITS-1:0] o_Data;
   logic                o_Data_DV;
   logic                o_Busy;
   logic                o_Done;
   logic                o_Error;
   logic                o_Wrapped;
   logic [CNT_BITS-1:0] o_Period;

   modport slave (
      input  i_Start, i_Abort, i_Seed, i_Steps,
      input  i_LFSR_Data, i_LFSR_Done,
      output o_LFSR_Enable, o_LFSR_Seed_DV, o_LFSR_Seed_Data,
      output o_Data, o_Data_DV, o_Busy, o_Done, o_Error,
      output o_Wrapped, o_Period
   );

   modport master (
      output i_Start, i_Abort, i_Seed, i_Steps,
      output i_LFSR_Data, i_LFSR_Done,
      input  o_LFSR_Enable, o_LFSR_Seed_DV, o_LFSR_Seed_Data,
      input  o_Data, o_Data_DV, o_Busy, o_Done, o_Error,
      input  o_Wrapped, o_Period
   );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for an external LFSR: seeds it, runs it for a set number of
// steps, samples each state and records the first wrap (period).
// Ports: i_Clk, i_Rst_L (sync, active-low), bus (lfsr_seq_ctrl_if.slave).
module lfsr_seq_ctrl #(
   parameter int NUM_BITS = 4,
   parameter int CNT_BITS = 16
) (
   input logic             i_Clk,
   input logic             i_Rst_L,
   lfsr_seq_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      SEED,
      RUN,
      FINISH
   } state_t;

   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

   state_t              state;
   logic [CNT_BITS-1:0] steps_q;
   logic [CNT_BITS-1:0] cnt_q;

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state                <= IDLE;
         steps_q              <= '0;
         cnt_q                <= '0;
         bus.o_LFSR_Enable    <= 1'b0;
         bus.o_LFSR_Seed_DV   <= 1'b0;
         bus.o_LFSR_Seed_Data <= '0;
         bus.o_Data           <= '0;
         bus.o_Data_DV        <= 1'b0;
         bus.o_Busy           <= 1'b0;
         bus.o_Done           <= 1'b0;
         bus.o_Error          <= 1'b0;
         bus.o_Wrapped        <= 1'b0;
         bus.o_Period         <= '0;
      end else begin
         bus.o_Data_DV <= 1'b0;
         bus.o_Done    <= 1'b0;
         bus.o_Error   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.i_Start) begin
                  steps_q       <= bus.i_Steps;
                  bus.o_Wrapped <= 1'b0;
                  bus.o_Period  <= '0;
                  bus.o_Busy    <= 1'b1;
                  if (bus.i_Seed == '0) begin
                     // an all-zero seed would lock the LFSR
                     state       <= FINISH;
                     bus.o_Done  <= 1'b1;
                     bus.o_Error <= 1'b1;
                  end else begin
                     state                <= SEED;
                     bus.o_LFSR_Seed_DV   <= 1'b1;
                     bus.o_LFSR_Seed_Data <= bus.i_Seed;
                  end
               end
            end
            SEED: begin
               bus.o_LFSR_Seed_DV <= 1'b0;
               cnt_q              <= '0;
               if (bus.i_Abort) begin
                  state       <= FINISH;
                  bus.o_Done  <= 1'b1;
                  bus.o_Error <= 1'b1;
               end else if (steps_q == '0) begin
                  state      <= FINISH;
                  bus.o_Done <= 1'b1;
               end else begin
                  state             <= RUN;
                  bus.o_LFSR_Enable <= 1'b1;
               end
            end
            RUN: begin
               if (bus.i_Abort) begin
                  // abort beats a coincident last step
                  state             <= FINISH;
                  bus.o_LFSR_Enable <= 1'b0;
                  bus.o_Done        <= 1'b1;
                  bus.o_Error       <= 1'b1;
               end else begin
                  bus.o_Data    <= bus.i_LFSR_Data;
                  bus.o_Data_DV <= 1'b1;
                  cnt_q         <= cnt_q + CNT_ONE;
                  // step 0 is the seed itself, so Done there is no wrap
                  if (bus.i_LFSR_Done && !bus.o_Wrapped
                      && cnt_q != '0) begin
                     bus.o_Wrapped <= 1'b1;
                     bus.o_Period  <= cnt_q;
                  end
                  if (cnt_q == steps_q - CNT_ONE) begin
                     state             <= FINISH;
                     bus.o_LFSR_Enable <= 1'b0;
                     bus.o_Done        <= 1'b1;
                  end
               end
            end
            FINISH: begin
               state      <= IDLE;
               bus.o_Busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
